// File: rtl/alu_shift_sequencer.sv
// Iterative shifter for SLL/SRL/SRA ALU ops: moves STEP bits per cycle,
// stalls the pipeline while busy and pulses done_o with the result.
module alu_shift_sequencer #(
  parameter int XLEN    = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [3:0]         alu_ctrl_i,
  input  logic [XLEN-1:0]    src_a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [XLEN-1:0]    result_o
);

  localparam logic [3:0] CTRL_SLL = 4'b0111;
  localparam logic [3:0] CTRL_SRL = 4'b1000;
  localparam logic [3:0] CTRL_SRA = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA} op_t;

  state_t             state;
  op_t                op;
  op_t                op_in;
  logic               fill_bit;
  logic [SHAMT_W-1:0] count;
  logic [SHAMT_W-1:0] count_next;
  logic [XLEN-1:0]    result_q;
  logic [XLEN-1:0]    shift_next;
  logic               is_shift;
  logic               accept;

  always_comb begin
    is_shift = 1'b0;
    op_in    = OP_SLL;
    case (alu_ctrl_i)
      CTRL_SLL: begin is_shift = 1'b1; op_in = OP_SLL; end
      CTRL_SRL: begin is_shift = 1'b1; op_in = OP_SRL; end
      CTRL_SRA: begin is_shift = 1'b1; op_in = OP_SRA; end
      default:  begin is_shift = 1'b0; op_in = OP_SLL; end
    endcase
  end

  assign accept = start_i & is_shift & ((state == S_IDLE) | (state == S_DONE)) & ~flush_i;

  // One single-bit stage per STEP; stages beyond the remaining count pass through.
  always_comb begin
    shift_next = result_q;
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(count)) begin
        if (op == OP_SLL)
          shift_next = {shift_next[XLEN-2:0], 1'b0};
        else
          shift_next = {(op == OP_SRA) & fill_bit, shift_next[XLEN-1:1]};
      end
    end
    if (int'(count) < STEP)
      count_next = '0;
    else
      count_next = count - SHAMT_W'(STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op       <= OP_SLL;
      fill_bit <= 1'b0;
      count    <= '0;
      result_q <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            result_q <= src_a_i;
            op       <= op_in;
            fill_bit <= src_a_i[XLEN-1];
            count    <= shamt_i;
            state    <= (shamt_i == '0) ? S_DONE : S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          result_q <= shift_next;
          count    <= count_next;
          if (count_next == '0)
            state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A flush drops the stall immediately, even mid-shift.
  assign busy_o   = (state == S_SHIFT);
  assign done_o   = (state == S_DONE);
  assign stall_o  = accept | (busy_o & ~flush_i);
  assign result_o = result_q;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer: a STEP=1 and a STEP=4 instance,
// with expected results and done cycles queued at issue and checked on done.
module tb_alu_shift_sequencer;

  localparam logic [3:0] SLL = 4'b0111;
  localparam logic [3:0] SRL = 4'b1000;
  localparam logic [3:0] SRA = 4'b1001;
  localparam logic [3:0] ADD = 4'b0000;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start, start4, flush;
  logic [3:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [4:0]  shamt;
  logic        stall1, busy1, done1;
  logic [31:0] result1;
  logic        stall4, busy4, done4;
  logic [31:0] result4;

  exp_t q1[$];
  exp_t q4[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_shift_sequencer #(.XLEN(32), .STEP(1), .SHAMT_W(5)) dut1 (
    .clk(clk), .rst(rst), .start_i(start), .alu_ctrl_i(alu_ctrl), .src_a_i(src_a),
    .shamt_i(shamt), .flush_i(flush), .stall_o(stall1), .busy_o(busy1),
    .done_o(done1), .result_o(result1)
  );

  alu_shift_sequencer #(.XLEN(32), .STEP(4), .SHAMT_W(5)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .alu_ctrl_i(alu_ctrl), .src_a_i(src_a),
    .shamt_i(shamt), .flush_i(flush), .stall_o(stall4), .busy_o(busy4),
    .done_o(done4), .result_o(result4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [3:0] ctrl, input logic [31:0] a,
                                        input logic [4:0] sh);
    case (ctrl)
      SLL:     return a << sh;
      SRL:     return a >> sh;
      SRA:     return $signed(a) >>> sh;
      default: return a;
    endcase
  endfunction

  function automatic logic model_is_shift(input logic [3:0] ctrl);
    return (ctrl == SLL) || (ctrl == SRL) || (ctrl == SRA);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] ctrl, input logic [31:0] a,
                                input logic [4:0] sh, input bit push1, input bit use4,
                                input string tag);
    exp_t e;
    alu_ctrl = ctrl;
    src_a    = a;
    shamt    = sh;
    start    = 1'b1;
    start4   = use4;
    #1;
    check({tag, "_accept_stall"}, 32'(stall1), 32'(model_is_shift(ctrl)));
    if (push1) begin
      e.res = model(ctrl, a, sh);
      e.cyc = cyc + int'(sh) + 1;
      q1.push_back(e);
    end
    if (use4) begin
      e.res = model(ctrl, a, sh);
      e.cyc = cyc + (int'(sh) + 3) / 4 + 1;
      q4.push_back(e);
    end
    step();
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles, input string tag);
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    check({tag, "_drained"}, 32'(q1.size() + q4.size()), 32'd0);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding op.
  always @(negedge clk) begin
    exp_t e;
    if (done1) begin
      check("dut1_done_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("dut1_result", result1, e.res);
        check("dut1_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (done4) begin
      check("dut4_done_expected", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check("dut4_result", result4, e.res);
        check("dut4_done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    alu_ctrl = ADD;
    src_a    = '0;
    shamt    = '0;
    start    = 1'b0;
    start4   = 1'b0;
    flush    = 1'b0;
    step();
    step();
    check("reset_result", result1, 32'h0);
    check("reset_busy", 32'(busy1), 32'd0);
    check("reset_done", 32'(done1), 32'd0);
    check("reset_stall", 32'(stall1), 32'd0);
    check("reset_busy4", 32'(busy4 | stall4), 32'd0);
    rst = 1'b0;
    step();

    $display("[TB] SLL 0x1 by 4");
    apply_stimulus(SLL, 32'h0000_0001, 5'd4, 1'b1, 1'b0, "sll4");
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("sll4_busy", 32'(busy1), 32'd1);
      check("sll4_stall", 32'(stall1), 32'd1);
      step();
    end
    @(negedge clk);
    check("sll4_done", 32'(done1), 32'd1);
    check("sll4_done_stall", 32'(stall1), 32'd0);
    step();
    repeat (3) step();
    check("sll4_hold_result", result1, 32'h0000_0010);
    check("sll4_hold_done", 32'(done1), 32'd0);

    $display("[TB] SRA/SRL by 31, STEP 1 and 4");
    apply_stimulus(SRA, 32'h8000_0000, 5'd31, 1'b1, 1'b1, "sra31");
    wait_drain(60, "sra31");
    apply_stimulus(SRL, 32'h8000_0000, 5'd31, 1'b1, 1'b0, "srl31");
    wait_drain(60, "srl31");

    $display("[TB] zero shift then back-to-back");
    apply_stimulus(SRL, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, "srl0");
    @(negedge clk);
    check("srl0_done_stall", 32'(stall1), 32'd0);
    check("srl0_done", 32'(done1), 32'd1);
    apply_stimulus(SLL, 32'hDEAD_BEEF, 5'd1, 1'b1, 1'b0, "b2b_sll1");
    wait_drain(10, "b2b");

    $display("[TB] non-shift op and start during SHIFT");
    apply_stimulus(ADD, 32'h0000_1234, 5'd3, 1'b0, 1'b0, "add");
    @(negedge clk);
    check("add_busy", 32'(busy1), 32'd0);
    check("add_done", 32'(done1), 32'd0);
    step();
    apply_stimulus(SLL, 32'h0000_0005, 5'd3, 1'b1, 1'b0, "sll3");
    alu_ctrl = SRL;
    src_a    = 32'hFFFF_FFFF;
    shamt    = 5'd1;
    start    = 1'b1;
    #1;
    check("ignored_start_stall", 32'(stall1), 32'd1);
    step();
    step();
    start = 1'b0;
    wait_drain(10, "sll3");
    repeat (3) step();
    check("sll3_result", result1, 32'h0000_0028);

    $display("[TB] flush mid-shift");
    apply_stimulus(SLL, 32'h0000_0001, 5'd10, 1'b0, 1'b0, "sll10");
    step();
    step();
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall1), 32'd0);
    step();
    flush = 1'b0;
    #1;
    check("flush_busy", 32'(busy1), 32'd0);
    check("flush_done", 32'(done1), 32'd0);
    check("flush_stall_after", 32'(stall1), 32'd0);
    check("flush_result_kept", result1, 32'h0000_0004);
    apply_stimulus(SRA, 32'hF000_0000, 5'd8, 1'b1, 1'b0, "sra8");
    wait_drain(20, "sra8");

    $display("[TB] async reset mid-shift");
    apply_stimulus(SLL, 32'h0000_0001, 5'd20, 1'b0, 1'b0, "sll20");
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("areset_result", result1, 32'h0);
    check("areset_busy", 32'(busy1), 32'd0);
    check("areset_done", 32'(done1), 32'd0);
    check("areset_stall", 32'(stall1), 32'd0);
    #2;
    rst = 1'b0;
    step();
    apply_stimulus(SLL, 32'h0000_0003, 5'd2, 1'b1, 1'b0, "sll2");
    wait_drain(10, "sll2");
    repeat (2) step();
    check("final_queue_empty", 32'(q1.size() + q4.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
